// File: rtl/arbitro_mux2x1_if.sv
// Bus between two requesters and the round-robin burst arbiter feeding a shared 2:1 datapath.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface arbitro_mux2x1_if;
   logic        req0;
   logic        req1;
   logic [15:0] entrada0;
   logic [15:0] entrada1;
   logic        ack0;
   logic        ack1;
   logic        M;
   logic [15:0] resultado;
   logic        valido;

   modport slave (
      input  req0, req1, entrada0, entrada1,
      output ack0, ack1, M, resultado, valido
   );

   modport master (
      output req0, req1, entrada0, entrada1,
      input  ack0, ack1, M, resultado, valido
   );
endinterface

// File: rtl/arbitro_mux2x1.sv
// Two-requester burst arbiter: grants up to MAX_RAJADA words per turn, alternates on ties,
// and registers the accepted word onto resultado one cycle after its ack.
module arbitro_mux2x1 #(
   parameter int unsigned MAX_RAJADA = 4
) (
   input logic               clock,
   input logic               reset_n,
   arbitro_mux2x1_if.slave   bus
);

   typedef enum logic [1:0] {
      LIVRE    = 2'd0,
      CONCEDE0 = 2'd1,
      CONCEDE1 = 2'd2
   } estado_t;

   localparam logic [3:0] LIMITE = 4'(MAX_RAJADA);

   estado_t     r_estado;
   estado_t     w_proximo;
   logic [3:0]  r_cont;
   logic        r_ultimo;
   logic        r_M;
   logic [15:0] r_resultado;
   logic        r_valido;
   logic        w_ack0;
   logic        w_ack1;
   logic        w_aceito;
   logic        w_fimRajada;

   assign w_ack0      = (r_estado == CONCEDE0) && bus.req0;
   assign w_ack1      = (r_estado == CONCEDE1) && bus.req1;
   assign w_aceito    = w_ack0 || w_ack1;
   assign w_fimRajada = w_aceito && ((r_cont + 4'd1) == LIMITE);

   // Burst ends either when the owner drops its request or when the word limit is hit;
   // at the limit the grant only moves if the other side is actually waiting.
   always_comb begin
      w_proximo = r_estado;
      unique case (r_estado)
         LIVRE: begin
            if (bus.req0 && bus.req1)
               w_proximo = r_ultimo ? CONCEDE0 : CONCEDE1;
            else if (bus.req0)
               w_proximo = CONCEDE0;
            else if (bus.req1)
               w_proximo = CONCEDE1;
         end
         CONCEDE0: begin
            if (!bus.req0)
               w_proximo = bus.req1 ? CONCEDE1 : LIVRE;
            else if (w_fimRajada && bus.req1)
               w_proximo = CONCEDE1;
         end
         CONCEDE1: begin
            if (!bus.req1)
               w_proximo = bus.req0 ? CONCEDE0 : LIVRE;
            else if (w_fimRajada && bus.req0)
               w_proximo = CONCEDE0;
         end
         default: w_proximo = LIVRE;
      endcase
   end

   // M follows the state being entered so it already points at the owner during its ack cycles.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_estado    <= LIVRE;
         r_cont      <= 4'd0;
         r_ultimo    <= 1'b1;
         r_M         <= 1'b0;
         r_resultado <= 16'h0000;
         r_valido    <= 1'b0;
      end else begin
         r_estado <= w_proximo;
         if (w_proximo == CONCEDE0)
            r_M <= 1'b0;
         else if (w_proximo == CONCEDE1)
            r_M <= 1'b1;
         r_valido <= w_aceito;
         if (w_ack0) begin
            r_resultado <= bus.entrada0;
            r_ultimo    <= 1'b0;
         end else if (w_ack1) begin
            r_resultado <= bus.entrada1;
            r_ultimo    <= 1'b1;
         end
         if (w_aceito && !w_fimRajada)
            r_cont <= r_cont + 4'd1;
         else
            r_cont <= 4'd0;
      end
   end

   assign bus.ack0      = w_ack0;
   assign bus.ack1      = w_ack1;
   assign bus.M         = r_M;
   assign bus.resultado = r_resultado;
   assign bus.valido    = r_valido;

endmodule

// File: tb/tb_arbitro_mux2x1.sv
// Directed bench for arbitro_mux2x1 (MAX_RAJADA = 4): each cycle drives requests at the falling
// edge and checks acks, M, valido and resultado against hand-derived values shortly after.
module tb_arbitro_mux2x1;

   logic clock;
   logic reset_n;
   int   vectorsApplied = 0;
   int   miscompares    = 0;
   int   cycleNo        = 0;

   arbitro_mux2x1_if bus ();

   arbitro_mux2x1 #(.MAX_RAJADA(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: every check in the bench is counted and reported here.
   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      vectorsApplied++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", tag, cycleNo, observed, expected);
      end
   endtask

   task automatic checkAll(input logic eAck0, input logic eAck1, input logic eM,
                           input logic eVal, input logic [15:0] eRes);
      checkOutput("ack0", {15'd0, bus.ack0}, {15'd0, eAck0});
      checkOutput("ack1", {15'd0, bus.ack1}, {15'd0, eAck1});
      checkOutput("ackExcl", {15'd0, bus.ack0 & bus.ack1}, 16'd0);
      checkOutput("M", {15'd0, bus.M}, {15'd0, eM});
      checkOutput("valido", {15'd0, bus.valido}, {15'd0, eVal});
      checkOutput("resultado", bus.resultado, eRes);
   endtask

   // One clock cycle: drive at the falling edge, check before the next rising edge.
   task automatic applyStimulus(input logic r0, input logic r1,
                                input logic [15:0] d0, input logic [15:0] d1,
                                input logic eAck0, input logic eAck1, input logic eM,
                                input logic eVal, input logic [15:0] eRes);
      @(negedge clock);
      cycleNo++;
      bus.req0     = r0;
      bus.req1     = r1;
      bus.entrada0 = d0;
      bus.entrada1 = d1;
      #1;
      checkAll(eAck0, eAck1, eM, eVal, eRes);
   endtask

   task automatic resetDut();
      @(negedge clock);
      reset_n      = 1'b0;
      bus.req0     = 1'b1;
      bus.req1     = 1'b1;
      bus.entrada0 = 16'hDEAD;
      bus.entrada1 = 16'hBEEF;
      @(posedge clock);
      @(posedge clock);
      #1;
      checkAll(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      @(negedge clock);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      reset_n  = 1'b1;
   endtask

   initial begin
      reset_n      = 1'b0;
      bus.req0     = 1'b0;
      bus.req1     = 1'b0;
      bus.entrada0 = 16'h0000;
      bus.entrada1 = 16'h0000;

      resetDut();

      // Single requester, three words.
      applyStimulus(1, 0, 16'h0001, 16'h0000, 0, 0, 0, 0, 16'h0000);
      applyStimulus(1, 0, 16'h0001, 16'h0000, 1, 0, 0, 0, 16'h0000);
      applyStimulus(1, 0, 16'h0002, 16'h0000, 1, 0, 0, 1, 16'h0001);
      applyStimulus(1, 0, 16'h0003, 16'h0000, 1, 0, 0, 1, 16'h0002);
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0003);
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0003);

      resetDut();

      // Tie after reset: four from 0, four from 1, back to 0, no gap.
      applyStimulus(1, 1, 16'hA001, 16'hB001, 0, 0, 0, 0, 16'h0000);
      applyStimulus(1, 1, 16'hA001, 16'hB001, 1, 0, 0, 0, 16'h0000);
      applyStimulus(1, 1, 16'hA002, 16'hB001, 1, 0, 0, 1, 16'hA001);
      applyStimulus(1, 1, 16'hA003, 16'hB001, 1, 0, 0, 1, 16'hA002);
      applyStimulus(1, 1, 16'hA004, 16'hB001, 1, 0, 0, 1, 16'hA003);
      applyStimulus(1, 1, 16'hA005, 16'hB001, 0, 1, 1, 1, 16'hA004);
      applyStimulus(1, 1, 16'hA005, 16'hB002, 0, 1, 1, 1, 16'hB001);
      applyStimulus(1, 1, 16'hA005, 16'hB003, 0, 1, 1, 1, 16'hB002);
      applyStimulus(1, 1, 16'hA005, 16'hB004, 0, 1, 1, 1, 16'hB003);
      applyStimulus(1, 1, 16'hA005, 16'hB005, 1, 0, 0, 1, 16'hB004);
      applyStimulus(1, 1, 16'hA006, 16'hB005, 1, 0, 0, 1, 16'hA005);
      applyStimulus(1, 1, 16'hA007, 16'hB005, 1, 0, 0, 1, 16'hA006);
      applyStimulus(1, 1, 16'hA008, 16'hB005, 1, 0, 0, 1, 16'hA007);

      // Grant to 1, which drops after two words; 0 takes over directly.
      applyStimulus(1, 1, 16'hA009, 16'hB005, 0, 1, 1, 1, 16'hA008);
      applyStimulus(1, 1, 16'hA009, 16'hB006, 0, 1, 1, 1, 16'hB005);
      applyStimulus(1, 0, 16'hA009, 16'h0000, 0, 0, 1, 1, 16'hB006);
      applyStimulus(1, 0, 16'hA009, 16'h0000, 1, 0, 0, 0, 16'hB006);
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hA009);
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'hA009);

      // Requester 1 alone for ten words: the limit must not break the burst.
      applyStimulus(0, 1, 16'h0000, 16'hC001, 0, 0, 0, 0, 16'hA009);
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(0, 1, 16'h0000, 16'hC000 + 16'(k), 0, 1, 1, (k > 1),
                       (k == 1) ? 16'hA009 : 16'hC000 + 16'(k - 1));
      end
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'hC00A);
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'hC00A);

      // Reset in the middle of word 2 of a burst.
      applyStimulus(1, 0, 16'hD001, 16'h0000, 0, 0, 1, 0, 16'hC00A);
      applyStimulus(1, 0, 16'hD001, 16'h0000, 1, 0, 0, 0, 16'hC00A);
      applyStimulus(1, 1, 16'hD002, 16'hE001, 1, 0, 0, 1, 16'hD001);
      #1;
      reset_n = 1'b0;
      #1;
      checkAll(0, 0, 0, 0, 16'h0000);
      @(posedge clock);
      #1;
      checkAll(0, 0, 0, 0, 16'h0000);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      checkAll(0, 0, 0, 0, 16'h0000);
      applyStimulus(1, 1, 16'hD002, 16'hE001, 1, 0, 0, 0, 16'h0000);
      applyStimulus(1, 1, 16'hD003, 16'hE001, 1, 0, 0, 1, 16'hD002);
      applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'hD003);

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule

// File: doc/arbitro_mux2x1.md
ARBITRO_MUX2X1 -- requirements
Module: arbitro_mux2x1

Interface
REQ-001 Parameter: MAX_RAJADA, default 4, maximum words one requester may move per grant (legal 1..15).
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req0  input  1  requester 0 has a word on entrada0; held until accepted.
REQ-005 Port: req1  input  1  requester 1 has a word on entrada1; held until accepted.
REQ-006 Port: entrada0  input  16  requester 0 data word.
REQ-007 Port: entrada1  input  16  requester 1 data word.
REQ-008 Port: ack0  output  1  combinational; high when the word on entrada0 is accepted at the next rising edge.
REQ-009 Port: ack1  output  1  combinational; high when the word on entrada1 is accepted at the next rising edge.
REQ-010 Port: M  output  1  registered select for the shared 2:1 datapath; 0 selects entrada0, 1 selects entrada1.
REQ-011 Port: resultado  output  16  registered word accepted in the previous cycle.
REQ-012 Port: valido  output  1  registered; high for one cycle per word present on resultado.

Function
REQ-013 The FSM SHALL have exactly three states: LIVRE (no grant), CONCEDE0 (grant to 0), CONCEDE1 (grant to 1).
REQ-014 In LIVRE, ack0 = ack1 = 0 and no word is accepted.
REQ-015 LIVRE, exactly one reqX high -> next state CONCEDEX.
REQ-016 LIVRE, both high -> next state grants the requester other than the `ultimo` register (last served); `ultimo` resets to 1, so requester 0 wins the first tie.
REQ-017 In CONCEDEX, ackX = reqX; the other ack = 0.
REQ-018 On each edge with ackX = 1: resultado <= entradaX, valido <= 1, ultimo <= X, and the 4-bit burst counter increments.
REQ-019 On each edge with no accepted word: valido <= 0, and resultado holds its value.
REQ-020 Accepted word appears on resultado/valido exactly one cycle after the ack cycle; throughput is one word per cycle during a grant.
REQ-021 M SHALL equal X while in CONCEDEX and hold its last value in LIVRE.
REQ-022 CONCEDEX with reqX = 0 -> next state CONCEDEY if reqY = 1, else LIVRE; counter cleared.
REQ-023 CONCEDEX, word accepted and counter reaches MAX_RAJADA -> next state CONCEDEY if reqY = 1; otherwise remain CONCEDEX; counter cleared in both cases.
REQ-024 Grant switches SHALL occur directly between CONCEDE0 and CONCEDE1 without passing through LIVRE; no idle cycle between bursts when both request.
REQ-025 At most one of ack0/ack1 SHALL be high in any cycle; no word is ever duplicated or dropped.
REQ-026 With MAX_RAJADA = 1, requests from both requesters SHALL alternate word by word.

Reset
REQ-027 While reset_n = 0, regardless of clock: state = LIVRE, counter = 0, ultimo = 1, M = 0, resultado = 16'h0000, valido = 0, ack0 = ack1 = 0.
REQ-028 Reset asserted mid-burst aborts the burst immediately; an in-flight word is discarded, not delivered after reset release.
REQ-029 The first rising edge after reset_n rises SHALL evaluate LIVRE transitions normally.

Verification
REQ-030 Single requester: req0 = 1 for 3 words 16'h0001, 16'h0002, 16'h0003 -> ack0 high 3 cycles, resultado shows 1, 2, 3 with valido high one cycle later each; M = 0.
REQ-031 Tie after reset: req0 = req1 = 1 continuously, MAX_RAJADA = 4 -> 4 words from entrada0 (M = 0), then 4 from entrada1 (M = 1), no gap cycle, repeating.
REQ-032 Early release: grant to 1, req1 drops after 2 words while req0 = 1 -> next cycle CONCEDE0, ack0 = 1, M = 0.
REQ-033 Burst limit, no contender: req1 = 1 alone for 10 words -> ack1 high all 10 cycles, M stays 1, valido high 10 consecutive cycles.
REQ-034 Reset mid-burst: reset_n low asynchronously in word 2 of a burst -> valido = 0, resultado = 16'h0000, acks 0 within the same cycle; after release with req0 = req1 = 1, requester 0 granted first.
REQ-035 Checker on every cycle: ack0 & ack1 = 0, and words on resultado equal the accepted entrada words in order.
